// File: rtl/decode_queue.sv
// RV32I decoder feeding a DEPTH-entry queue of registered control bundles.
// Fetch pushes raw instructions; execute pops fully decoded entries.
module decode_queue #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter bit EN_SHIFT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_alu_op,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [1:0]      out_rf_src,
  output logic [XLEN-1:0] out_branch_target,
  output logic            out_illegal,
  output logic [15:0]     illegal_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_AND = 5'd2,  ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4,  ALU_SLT = 5'd5,  ALU_SLL = 5'd6,  ALU_SRL = 5'd7;
  localparam logic [4:0] ALU_SRA = 5'd8,  ALU_LUI = 5'd9,  ALU_BEQ = 5'd10, ALU_BNE = 5'd11;
  localparam logic [4:0] ALU_BLT = 5'd12, ALU_BGE = 5'd13, ALU_JAL = 5'd14, ALU_JALR = 5'd15;
  localparam logic [4:0] ALU_ILL = 5'd31;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            we;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      rf_src;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  entry_t          w_dec;
  logic            w_legal;
  logic            w_shift;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_ill_cnt;
  logic            w_push, w_pop;
  entry_t          w_head;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign w_imm_i  = XLEN'($signed(in_instr[31:20]));
  assign w_imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign w_imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign w_imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  assign w_imm_u  = XLEN'($signed({in_instr[31:12], 12'h000}));

  always_comb begin
    w_dec    = '0;
    w_dec.pc = in_pc;
    w_legal  = 1'b1;
    w_shift  = 1'b0;
    case (w_opcode)
      7'b0110011: begin
        w_dec.rs1 = in_instr[19:15];
        w_dec.rs2 = in_instr[24:20];
        w_dec.rd  = in_instr[11:7];
        w_dec.we  = 1'b1;
        case ({w_f7, w_f3})
          10'b0000000_000: w_dec.alu_op = ALU_ADD;
          10'b0000000_001: begin w_dec.alu_op = ALU_SLL; w_shift = 1'b1; end
          10'b0000000_010: w_dec.alu_op = ALU_SLT;
          10'b0000000_100: w_dec.alu_op = ALU_XOR;
          10'b0000000_101: begin w_dec.alu_op = ALU_SRL; w_shift = 1'b1; end
          10'b0000000_110: w_dec.alu_op = ALU_OR;
          10'b0000000_111: w_dec.alu_op = ALU_AND;
          10'b0100000_000: w_dec.alu_op = ALU_SUB;
          10'b0100000_101: begin w_dec.alu_op = ALU_SRA; w_shift = 1'b1; end
          default:         w_legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        w_dec.rs1 = in_instr[19:15];
        w_dec.rd  = in_instr[11:7];
        w_dec.imm = w_imm_i;
        w_dec.we  = 1'b1;
        case (w_f3)
          3'b000: w_dec.alu_op = ALU_ADD;
          3'b010: w_dec.alu_op = ALU_SLT;
          3'b100: w_dec.alu_op = ALU_XOR;
          3'b110: w_dec.alu_op = ALU_OR;
          3'b111: w_dec.alu_op = ALU_AND;
          3'b001: begin
            w_shift       = 1'b1;
            w_dec.alu_op  = ALU_SLL;
            w_legal       = (w_f7 == 7'b0000000);
          end
          3'b101: begin
            w_shift       = 1'b1;
            w_dec.alu_op  = (w_f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            w_legal       = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          end
          default: w_legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        w_legal        = (w_f3 == 3'b010);
        w_dec.alu_op   = ALU_ADD;
        w_dec.rs1      = in_instr[19:15];
        w_dec.rd       = in_instr[11:7];
        w_dec.imm      = w_imm_i;
        w_dec.mem_read = 1'b1;
        w_dec.rf_src   = 2'b01;
        w_dec.we       = 1'b1;
      end
      7'b0100011: begin
        w_legal         = (w_f3 == 3'b010);
        w_dec.alu_op    = ALU_ADD;
        w_dec.rs1       = in_instr[19:15];
        w_dec.rs2       = in_instr[24:20];
        w_dec.imm       = w_imm_s;
        w_dec.mem_write = 1'b1;
      end
      7'b1100011: begin
        w_dec.rs1    = in_instr[19:15];
        w_dec.rs2    = in_instr[24:20];
        w_dec.imm    = w_imm_b;
        w_dec.target = in_pc + w_imm_b;
        case (w_f3)
          3'b000:  w_dec.alu_op = ALU_BEQ;
          3'b001:  w_dec.alu_op = ALU_BNE;
          3'b100:  w_dec.alu_op = ALU_BLT;
          3'b101:  w_dec.alu_op = ALU_BGE;
          default: w_legal = 1'b0;
        endcase
      end
      7'b1101111: begin
        w_dec.alu_op = ALU_JAL;
        w_dec.rd     = in_instr[11:7];
        w_dec.imm    = w_imm_j;
        w_dec.target = in_pc + w_imm_j;
        w_dec.rf_src = 2'b11;
        w_dec.we     = 1'b1;
      end
      7'b1100111: begin
        w_legal      = (w_f3 == 3'b000);
        w_dec.alu_op = ALU_JALR;
        w_dec.rs1    = in_instr[19:15];
        w_dec.rd     = in_instr[11:7];
        w_dec.imm    = w_imm_i;
        w_dec.rf_src = 2'b11;
        w_dec.we     = 1'b1;
      end
      7'b0110111: begin
        w_dec.alu_op = ALU_LUI;
        w_dec.rd     = in_instr[11:7];
        w_dec.imm    = w_imm_u;
        w_dec.rf_src = 2'b10;
        w_dec.we     = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    // Illegal entries keep only the PC so the consumer can report the trap address.
    if (!w_legal || (w_shift && !EN_SHIFT)) begin
      w_dec         = '0;
      w_dec.pc      = in_pc;
      w_dec.alu_op  = ALU_ILL;
      w_dec.illegal = 1'b1;
    end
    if (w_dec.rd == 5'd0) w_dec.we = 1'b0;
  end

  // Handshake: a transfer on either side happens at a rising edge where valid and
  // ready are both high and flush is low; ready/valid are pure functions of the
  // registered count, never of the partner's signal.
  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ill_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
        if (w_dec.illegal && (r_ill_cnt != 16'hFFFF)) r_ill_cnt <= r_ill_cnt + 16'd1;
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head            = r_mem[r_rd_ptr];
  assign out_pc            = w_head.pc;
  assign out_alu_op        = w_head.alu_op;
  assign out_imm           = w_head.imm;
  assign out_rs1           = w_head.rs1;
  assign out_rs2           = w_head.rs2;
  assign out_rd            = w_head.rd;
  assign out_we            = w_head.we;
  assign out_mem_read      = w_head.mem_read;
  assign out_mem_write     = w_head.mem_write;
  assign out_rf_src        = w_head.rf_src;
  assign out_branch_target = w_head.target;
  assign out_illegal       = w_head.illegal;
  assign illegal_count     = r_ill_cnt;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (shifts enabled / disabled) driven in lockstep
// and compared against a reference decoder plus an instruction-order queue.
module tb_decode_queue;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        mr;
    logic        mw;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic        ill;
    logic [31:0] pc;
  } fld_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        a_in_ready, a_out_valid, a_we, a_mr, a_mw, a_ill;
  logic [31:0] a_pc, a_imm, a_tgt;
  logic [4:0]  a_alu, a_rs1, a_rs2, a_rd;
  logic [1:0]  a_src;
  logic [15:0] a_cnt;
  logic        b_in_ready, b_out_valid, b_we, b_mr, b_mw, b_ill;
  logic [31:0] b_pc, b_imm, b_tgt;
  logic [4:0]  b_alu, b_rs1, b_rs2, b_rd;
  logic [1:0]  b_src;
  logic [15:0] b_cnt;
  fld_t        obs_a, obs_b;

  logic [63:0] exp_q[$];
  int          cnt_a, cnt_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  decode_queue #(.XLEN(32), .DEPTH(DEPTH), .EN_SHIFT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_alu_op(a_alu), .out_imm(a_imm), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_rd(a_rd), .out_we(a_we), .out_mem_read(a_mr), .out_mem_write(a_mw),
    .out_rf_src(a_src), .out_branch_target(a_tgt), .out_illegal(a_ill), .illegal_count(a_cnt)
  );

  decode_queue #(.XLEN(32), .DEPTH(DEPTH), .EN_SHIFT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_alu_op(b_alu), .out_imm(b_imm), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_rd(b_rd), .out_we(b_we), .out_mem_read(b_mr), .out_mem_write(b_mw),
    .out_rf_src(b_src), .out_branch_target(b_tgt), .out_illegal(b_ill), .illegal_count(b_cnt)
  );

  assign obs_a = {a_alu, a_imm, a_rs1, a_rs2, a_rd, a_we, a_mr, a_mw, a_src, a_tgt, a_ill, a_pc};
  assign obs_b = {b_alu, b_imm, b_rs1, b_rs2, b_rd, b_we, b_mr, b_mw, b_src, b_tgt, b_ill, b_pc};

  // Reference decoder: classify the instruction, then fill fields by format.
  function automatic fld_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input bit en_sh);
    fld_t        r;
    int          alu;
    bit          shift;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          alu_by_f3[8];
    alu_by_f3 = '{0, 6, 5, -1, 4, 7, 3, 2};
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    r = '0;
    r.pc = pc;
    alu = -1;
    shift = 0;
    case (op)
      7'b0110011: begin
        if (f7 == 7'h00) alu = alu_by_f3[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 8;
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.rd = ins[11:7]; r.we = 1;
      end
      7'b0010011: begin
        alu = alu_by_f3[f3];
        if (f3 == 3'd1 && f7 != 7'h00) alu = -1;
        if (f3 == 3'd5) alu = (f7 == 7'h00) ? 7 : (f7 == 7'h20) ? 8 : -1;
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        r.rs1 = ins[19:15]; r.rd = ins[11:7]; r.we = 1;
        r.imm = 32'($signed(ins[31:20]));
      end
      7'b0000011: begin
        if (f3 == 3'd2) alu = 0;
        r.rs1 = ins[19:15]; r.rd = ins[11:7]; r.we = 1; r.mr = 1; r.src = 2'b01;
        r.imm = 32'($signed(ins[31:20]));
      end
      7'b0100011: begin
        if (f3 == 3'd2) alu = 0;
        r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.mw = 1;
        r.imm = 32'($signed({ins[31:25], ins[11:7]}));
      end
      7'b1100011: begin
        alu = (f3 == 3'd0) ? 10 : (f3 == 3'd1) ? 11 : (f3 == 3'd4) ? 12 : (f3 == 3'd5) ? 13 : -1;
        r.rs1 = ins[19:15]; r.rs2 = ins[24:20];
        r.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        r.tgt = pc + r.imm;
      end
      7'b1101111: begin
        alu = 14;
        r.rd = ins[11:7]; r.we = 1; r.src = 2'b11;
        r.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        r.tgt = pc + r.imm;
      end
      7'b1100111: begin
        if (f3 == 3'd0) alu = 15;
        r.rs1 = ins[19:15]; r.rd = ins[11:7]; r.we = 1; r.src = 2'b11;
        r.imm = 32'($signed(ins[31:20]));
      end
      7'b0110111: begin
        alu = 9;
        r.rd = ins[11:7]; r.we = 1; r.src = 2'b10;
        r.imm = {ins[31:12], 12'h000};
      end
      default: alu = -1;
    endcase
    if (alu < 0 || (shift && !en_sh)) begin
      r = '0;
      r.pc = pc;
      r.alu = 5'd31;
      r.ill = 1;
    end else begin
      r.alu = 5'(alu);
      if (r.rd == 5'd0) r.we = 0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_fields(input string p, input fld_t o, input fld_t e);
    chk({p, "_alu"}, 64'(o.alu), 64'(e.alu));
    chk({p, "_imm"}, 64'(o.imm), 64'(e.imm));
    chk({p, "_regs"}, 64'({o.rs1, o.rs2, o.rd}), 64'({e.rs1, e.rs2, e.rd}));
    chk({p, "_ctl"}, 64'({o.we, o.mr, o.mw, o.src}), 64'({e.we, e.mr, e.mw, e.src}));
    chk({p, "_target"}, 64'(o.tgt), 64'(e.tgt));
    chk({p, "_illegal"}, 64'(o.ill), 64'(e.ill));
    chk({p, "_pc"}, 64'(o.pc), 64'(e.pc));
  endtask

  task automatic check_state();
    bit v;
    v = (exp_q.size() != 0);
    chk("A_out_valid", 64'(a_out_valid), 64'(v));
    chk("B_out_valid", 64'(b_out_valid), 64'(v));
    chk("A_in_ready", 64'(a_in_ready), 64'(exp_q.size() < DEPTH));
    chk("B_in_ready", 64'(b_in_ready), 64'(exp_q.size() < DEPTH));
    chk("A_illegal_count", 64'(a_cnt), 64'(cnt_a));
    chk("B_illegal_count", 64'(b_cnt), 64'(cnt_b));
    if (v) begin
      compare_fields("A", obs_a, ref_decode(exp_q[0][31:0], exp_q[0][63:32], 1'b1));
      compare_fields("B", obs_b, ref_decode(exp_q[0][31:0], exp_q[0][63:32], 1'b0));
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge,
  // check at the next falling edge.
  task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rdy, input bit fl);
    bit   push, pop;
    fld_t da, db;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
    push = v && (exp_q.size() < DEPTH) && !fl;
    pop  = (exp_q.size() != 0) && rdy && !fl;
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back({pc, ins});
        da = ref_decode(ins, pc, 1'b1);
        db = ref_decode(ins, pc, 1'b0);
        if (da.ill && cnt_a < 65535) cnt_a++;
        if (db.ill && cnt_b < 65535) cnt_b++;
      end
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    exp_q.delete();
    cnt_a = 0; cnt_b = 0;
    #1;
    chk("A_reset_fields", 64'(obs_a), 64'(0));
    chk("B_reset_fields", 64'(obs_b), 64'(0));
    check_state();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops[8];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
    ins = $urandom;
    if ($urandom_range(0, 9) != 0) begin
      ins[6:0] = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 2) != 0) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
    end
    return ins;
  endfunction

  initial begin
    do_reset();

    // ADD x3,x1,x2 appears one cycle after acceptance, then drains.
    cycle(1, 32'h002081B3, 32'h100, 1, 0);
    chk("add_alu", 64'(a_alu), 64'd0);
    chk("add_regs", 64'({a_rs1, a_rs2, a_rd}), 64'({5'd1, 5'd2, 5'd3}));
    chk("add_we_src", 64'({a_we, a_src}), 64'({1'b1, 2'b00}));
    cycle(0, 32'h0, 32'h0, 1, 0);
    chk("add_drained", 64'(a_out_valid), 64'd0);

    // Backpressure: third instruction waits until a slot frees.
    cycle(1, 32'h00100093, 32'h300, 0, 0);
    cycle(1, 32'h00200113, 32'h304, 0, 0);
    chk("full_in_ready", 64'(a_in_ready), 64'd0);
    cycle(1, 32'h00300193, 32'h308, 0, 0);
    cycle(1, 32'h00300193, 32'h308, 1, 0);
    cycle(1, 32'h00300193, 32'h308, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // BEQ with imm -8 at 0x200.
    cycle(1, 32'hFE000CE3, 32'h200, 0, 0);
    chk("beq_alu", 64'(a_alu), 64'd10);
    chk("beq_imm", 64'(a_imm), 64'hFFFFFFF8);
    chk("beq_target", 64'(a_tgt), 64'h1F8);
    chk("beq_we", 64'(a_we), 64'd0);
    cycle(1, 32'h0040A283, 32'h204, 1, 0);
    chk("lw_ctl", 64'({a_mr, a_src, a_imm}), 64'({1'b1, 2'b01, 32'd4}));
    cycle(1, 32'h00100013, 32'h208, 1, 0);
    chk("addi_x0_we", 64'(a_we), 64'd0);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // Illegal instructions, shift disabled in B, flushed illegal push not counted.
    do_reset();
    cycle(1, 32'hFFFFFFFF, 32'h400, 1, 0);
    cycle(1, 32'h4030D093, 32'h404, 1, 0);
    chk("srai_b_alu", 64'({b_alu, b_ill}), 64'({5'd31, 1'b1}));
    chk("srai_a_alu", 64'(a_alu), 64'd8);
    chk("illegal_count_b", 64'(b_cnt), 64'd2);
    cycle(1, 32'h0000007F, 32'h408, 1, 1);
    chk("flush_count_b", 64'(b_cnt), 64'd2);
    chk("flush_valid", 64'(a_out_valid), 64'd0);

    // Asynchronous reset with a full queue.
    cycle(1, 32'h002081B3, 32'h500, 0, 0);
    cycle(1, 32'h0040A283, 32'h504, 0, 0);
    #2;
    rst = 1'b0;
    exp_q.delete();
    cnt_a = 0; cnt_b = 0;
    #1;
    chk("async_rst_fields", 64'(obs_a), 64'(0));
    chk("async_rst_valid", 64'(a_out_valid), 64'd0);
    chk("async_rst_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    cycle(0, 32'h0, 32'h0, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFFFFFC,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
